// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_sized.sv
// RV32I data memory: B/H/W loads and stores with sign/zero extension, byte strobes,
// alignment/range/size checks and a programmable number of wait states.
module dmem_sized #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              req_ready;
  logic              rsp_valid;
  logic              accept;
  logic              exec;
  logic              size_ok;
  logic              misaligned;
  logic              out_range;
  logic              acc_err;
  logic [3:0]        strobe;
  logic [31:0]       wrep;
  logic [31:0]       rword;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [31:0]       ldata;
  logic [IdxW-1:0]   ridx;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state_q == StIdle) && bus.req_valid;
  assign exec   = (state_q == StWait) && (cnt_q == '0);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StWait;
          cnt_d   = CntW'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        else             state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      f3_q    <= bus.req_funct3;
    end
  end

  // Access checks on the latched request; BU/HU encodings are load-only.
  always_comb begin
    size_ok    = 1'b1;
    misaligned = 1'b0;
    case (f3_q)
      3'b000: size_ok = 1'b1;
      3'b001: misaligned = addr_q[0];
      3'b010: misaligned = |addr_q[1:0];
      3'b100: size_ok = !we_q;
      3'b101: begin
        size_ok    = !we_q;
        misaligned = addr_q[0];
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign out_range = {2'b00, addr_q[31:2]} >= DEPTH_WORDS;
  assign acc_err   = !size_ok || misaligned || out_range;

  always_comb begin
    strobe = 4'b1111;
    wrep   = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        strobe = 4'b0001 << addr_q[1:0];
        wrep   = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strobe = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep   = {2{wdata_q[15:0]}};
      end
      default: begin
        strobe = 4'b1111;
        wrep   = wdata_q;
      end
    endcase
  end

  assign ridx  = addr_q[IdxW+1:2];
  assign rword = mem[ridx];
  assign lb    = rword[{addr_q[1:0], 3'b000} +: 8];
  assign lh    = rword[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ldata = {{24{lb[7]}}, lb};
      3'b100:  ldata = {24'b0, lb};
      3'b001:  ldata = {{16{lh[15]}}, lh};
      3'b101:  ldata = {16'b0, lh};
      default: ldata = rword;
    endcase
  end

  // Gating on rst keeps an abandoned request from committing at the reset edge.
  always_ff @(posedge clk) begin
    if (exec && we_q && !acc_err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) mem[ridx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (exec) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || we_q) ? '0 : ldata;
    end else if (state_q == StResp) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Two memories (256 words/no wait, 64 words/3 waits) driven with directed vectors
// and checked each cycle against a byte-level reference memory.
module tb_dmem_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  dmem_if if0 ();
  dmem_if if1 ();

  dmem_sized #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  dmem_sized #(.DEPTH_WORDS(64),  .WAIT_CYCLES(3)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  int unsigned depth [2] = '{256, 64};
  int unsigned waitc [2] = '{0, 3};

  logic        dv  [2];
  logic        dwe [2];
  logic [31:0] da  [2];
  logic [31:0] dwd [2];
  logic [2:0]  df3 [2];

  assign if0.req_valid  = dv[0];
  assign if0.req_we     = dwe[0];
  assign if0.req_addr   = da[0];
  assign if0.req_wdata  = dwd[0];
  assign if0.req_funct3 = df3[0];
  assign if1.req_valid  = dv[1];
  assign if1.req_we     = dwe[1];
  assign if1.req_addr   = da[1];
  assign if1.req_wdata  = dwd[1];
  assign if1.req_funct3 = df3[1];

  typedef struct {
    int          due;
    int          tag;
    logic [31:0] rdata;
    logic        err;
    bit          lit;
    logic [31:0] lrdata;
    logic        lerr;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mm [2][256];
  int          last_acc [2] = '{-100, -100};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          tag = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: bytes addressed directly, result assembled by arithmetic.
  task automatic model(input int s, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int          nb;
    int unsigned idx;
    int          lane;
    logic [31:0] w;
    rd  = '0;
    er  = 1'b0;
    idx = a >> 2;
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    if (nb == 0 || (we && f3[2])) er = 1'b1;
    if (nb > 0 && (a % nb) != 0) er = 1'b1;
    if (idx >= depth[s]) er = 1'b1;
    if (er) return;
    if (we) begin
      for (int b = 0; b < nb; b++) begin
        lane = int'(a % 4) + b;
        mm[s][idx][8*lane +: 8] = wd[8*b +: 8];
      end
    end else begin
      w = mm[s][idx] >> (8 * (a % 4));
      if (nb == 1)      rd = f3[2] ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      else if (nb == 2) rd = f3[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      else              rd = w;
    end
  endtask

  task automatic issue(input int s, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit lit, input logic [31:0] lrd,
                       input logic lerr);
    int   n;
    int   budget;
    exp_t e;
    logic rdy;
    @(posedge clk);
    #1;
    budget = 0;
    rdy = (s == 0) ? if0.req_ready : if1.req_ready;
    while (!rdy && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
      rdy = (s == 0) ? if0.req_ready : if1.req_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL dut%0d req_ready timeout: got 0 want 1", s);
      return;
    end
    dv[s]  = 1'b1;
    dwe[s] = we;
    da[s]  = a;
    dwd[s] = wd;
    df3[s] = f3;
    n = cyc;
    @(posedge clk);
    #1;
    dv[s] = 1'b0;
    last_acc[s] = n;
    model(s, we, a, wd, f3, e.rdata, e.err);
    e.due    = n + int'(waitc[s]) + 2;
    e.tag    = tag++;
    e.lit    = lit;
    e.lrdata = lrd;
    e.lerr   = lerr;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_side(input int s);
    logic        rv, rr, re, rs;
    logic [31:0] rd;
    bit          has;
    bit          exp_ready;
    exp_t        e;
    string       p;
    rv = (s == 0) ? if0.rsp_valid : if1.rsp_valid;
    rr = (s == 0) ? if0.req_ready : if1.req_ready;
    rd = (s == 0) ? if0.rsp_rdata : if1.rsp_rdata;
    re = (s == 0) ? if0.rsp_err   : if1.rsp_err;
    rs = (s == 0) ? rst0 : rst1;
    p  = $sformatf("dut%0d", s);
    if (rs) begin
      chk({p, " reset req_ready"}, 32'(rr), 32'd1);
      chk({p, " reset rsp_valid"}, 32'(rv), 32'd0);
      chk({p, " reset rsp_rdata"}, rd, 32'd0);
      chk({p, " reset rsp_err"},   32'(re), 32'd0);
      return;
    end
    exp_ready = !(cyc > last_acc[s] && cyc <= last_acc[s] + int'(waitc[s]) + 2);
    chk({p, " req_ready"}, 32'(rr), 32'(exp_ready));
    if (s == 0) has = (q0.size() > 0) && (q0[0].due == cyc);
    else        has = (q1.size() > 0) && (q1[0].due == cyc);
    chk({p, " rsp_valid"}, 32'(rv), 32'(has));
    if (has) begin
      e = (s == 0) ? q0.pop_front() : q1.pop_front();
      if (rv) begin
        chk($sformatf("%s req%0d rdata", p, e.tag), rd, e.rdata);
        chk($sformatf("%s req%0d err", p, e.tag), 32'(re), 32'(e.err));
        if (e.lit) begin
          chk($sformatf("%s req%0d literal rdata", p, e.tag), rd, e.lrdata);
          chk($sformatf("%s req%0d literal err", p, e.tag), 32'(re), 32'(e.lerr));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_side(0);
    check_side(1);
  end

  initial begin
    int n;
    for (int s = 0; s < 2; s++) begin
      dv[s] = 1'b0; dwe[s] = 1'b0; da[s] = '0; dwd[s] = '0; df3[s] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;

    // dut0: word round trip, byte and half lanes, alignment and size errors
    issue(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 1, 32'h0, 1'b0);
    issue(0, 0, 32'h10, 32'h0,        3'b010, 1, 32'hDEADBEEF, 1'b0);
    issue(0, 1, 32'h10, 32'h11223344, 3'b010, 1, 32'h0, 1'b0);
    issue(0, 1, 32'h13, 32'h00000080, 3'b000, 1, 32'h0, 1'b0);
    issue(0, 0, 32'h13, 32'h0,        3'b000, 1, 32'hFFFFFF80, 1'b0);
    issue(0, 0, 32'h13, 32'h0,        3'b100, 1, 32'h00000080, 1'b0);
    issue(0, 0, 32'h10, 32'h0,        3'b010, 1, 32'h80223344, 1'b0);
    issue(0, 1, 32'h20, 32'hA5A5A5A5, 3'b010, 1, 32'h0, 1'b0);
    issue(0, 1, 32'h22, 32'h1234BEEF, 3'b001, 1, 32'h0, 1'b0);
    issue(0, 0, 32'h22, 32'h0,        3'b001, 1, 32'hFFFFBEEF, 1'b0);
    issue(0, 0, 32'h22, 32'h0,        3'b101, 1, 32'h0000BEEF, 1'b0);
    issue(0, 0, 32'h21, 32'h0,        3'b001, 1, 32'h0, 1'b1);
    issue(0, 1, 32'h22, 32'h12345678, 3'b010, 1, 32'h0, 1'b1);
    issue(0, 1, 32'h20, 32'h77777777, 3'b100, 1, 32'h0, 1'b1);
    issue(0, 0, 32'h20, 32'h0,        3'b010, 1, 32'hBEEFA5A5, 1'b0);
    issue(0, 0, 32'h20, 32'h0,        3'b000, 1, 32'hFFFFFFA5, 1'b0);
    issue(0, 0, 32'h21, 32'h0,        3'b100, 1, 32'h000000A5, 1'b0);
    issue(0, 1, 32'h3FC, 32'h0BADF00D, 3'b010, 1, 32'h0, 1'b0);
    issue(0, 0, 32'h3FC, 32'h0,       3'b010, 1, 32'h0BADF00D, 1'b0);
    issue(0, 0, 32'h400, 32'h0,       3'b010, 1, 32'h0, 1'b1);

    // dut1: range (no index truncation), illegal load size
    issue(1, 1, 32'h0,   32'hCAFEF00D, 3'b010, 1, 32'h0, 1'b0);
    issue(1, 1, 32'h4,   32'h55AA55AA, 3'b010, 1, 32'h0, 1'b0);
    issue(1, 1, 32'h100, 32'hFFFFFFFF, 3'b010, 1, 32'h0, 1'b1);
    issue(1, 0, 32'h0,   32'h0,        3'b010, 1, 32'hCAFEF00D, 1'b0);
    issue(1, 0, 32'h0,   32'h0,        3'b011, 1, 32'h0, 1'b1);
    issue(1, 0, 32'h80000000, 32'h0,   3'b010, 1, 32'h0, 1'b1);
    issue(1, 1, 32'hFC, 32'h600DCAFE,  3'b010, 1, 32'h0, 1'b0);
    issue(1, 0, 32'hFC, 32'h0,         3'b010, 1, 32'h600DCAFE, 1'b0);

    // dut1: request lines wiggle while busy; they must be ignored
    issue(1, 0, 32'h4, 32'h0, 3'b010, 1, 32'h55AA55AA, 1'b0);
    for (int k = 0; k < 4; k++) begin
      dv[1]  = ~dv[1];
      dwe[1] = 1'b1;
      da[1]  = 32'h4;
      dwd[1] = 32'hFFFFFFFF;
      df3[1] = 3'b010;
      @(posedge clk);
      #1;
    end
    dv[1] = 1'b0;
    issue(1, 0, 32'h4, 32'h0, 3'b010, 1, 32'h55AA55AA, 1'b0);

    // dut1: reset during WAIT of a store abandons it
    @(posedge clk);
    #1;
    while (!if1.req_ready) begin
      @(posedge clk);
      #1;
    end
    dv[1] = 1'b1; dwe[1] = 1'b1; da[1] = 32'h0; dwd[1] = 32'h12345678; df3[1] = 3'b010;
    n = cyc;
    @(posedge clk);
    #1;
    dv[1] = 1'b0;
    last_acc[1] = n;
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    last_acc[1] = -100;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    issue(1, 0, 32'h0, 32'h0, 3'b010, 1, 32'hCAFEF00D, 1'b0);

    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending responses want 0", q0.size() + q1.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
